// File: rtl/first_guess_reg.sv
// Reciprocal seed for the Goldschmidt divider: one-hot F = 2^-(k+1), k = MSB index of d.
// Latency: 1 cycle, registered outputs. Backpressure: none, outputs update every cycle.
// Reset: asynchronous active-low, clears f and d_zero.
module first_guess_reg #(
    parameter int I_BITS = 32,
    parameter int F_BITS = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [I_BITS-1:0] d,
    output logic [I_BITS-1:0] f,
    output logic              d_zero
);

    // The divider places f directly below its binary point, so the fraction must fit it.
    if (F_BITS < I_BITS) begin : g_bad_widths
        $error("first_guess_reg: F_BITS must be >= I_BITS");
    end

    logic [I_BITS-1:0] f_d;
    logic [I_BITS-1:0] f_q;
    logic              d_zero_d;
    logic              d_zero_q;

    // Scanning upward lets the highest set bit overwrite lower ones (priority encode).
    // That bit at index k maps to output bit I_BITS-1-k, i.e. weight 2^-(k+1).
    always_comb begin
        f_d      = '0;
        d_zero_d = (d == '0);
        for (int i = 0; i < I_BITS; i++) begin
            if (d[i]) begin
                f_d = '0;
                f_d[I_BITS-1-i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_q      <= '0;
            d_zero_q <= 1'b0;
        end else begin
            f_q      <= f_d;
            d_zero_q <= d_zero_d;
        end
    end

    assign f      = f_q;
    assign d_zero = d_zero_q;

endmodule

// File: tb/tb_first_guess_reg.sv
// Self-checking bench for first_guess_reg: behavioural reference model plus directed literals.
module tb_first_guess_reg;

    logic        clk;
    logic        rst;
    logic [31:0] d;
    logic [31:0] f;
    logic        d_zero;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [31:0] exp_f;
    logic        exp_z;
    logic [31:0] exp_src;

    first_guess_reg #(.I_BITS(32), .F_BITS(40)) dut (
        .clk    (clk),
        .rst    (rst),
        .d      (d),
        .f      (f),
        .d_zero (d_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference seed: floor(log2 v) by repeated halving, then 2^-(k+1) as a 0.32 fraction.
    function automatic logic [31:0] seed(input logic [31:0] v);
        logic [31:0] t;
        int          k;
        if (v == 32'd0) return 32'd0;
        t = v;
        k = 0;
        while (t > 32'd1) begin
            t = t >> 1;
            k++;
        end
        return 32'h8000_0000 >> k;
    endfunction

    // Model: outputs follow the d seen at each active edge, cleared at once by reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_f   = 32'd0;
            exp_z   = 1'b0;
            exp_src = 32'd0;
        end else begin
            exp_f   = seed(d);
            exp_z   = (d == 32'd0);
            exp_src = d;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [63:0] prod;
            checks++;
            if (f !== exp_f || d_zero !== exp_z) begin
                errors++;
                $display("FAIL model_cmp: f=%h d_zero=%b, required f=%h d_zero=%b", f, d_zero, exp_f, exp_z);
            end
            if (exp_src != 32'd0) begin
                prod = {32'd0, exp_src} * {32'd0, f};
                checks++;
                if (!$onehot(f) || prod < 64'h8000_0000 || prod >= 64'h1_0000_0000) begin
                    errors++;
                    $display("FAIL range: d=%h f=%h d*f=%h, required one-hot f and d*f in [2^31,2^32)", exp_src, f, prod);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] ef, input logic ez);
        checks++;
        if (f !== ef || d_zero !== ez) begin
            errors++;
            $display("FAIL %s: f=%h d_zero=%b, required f=%h d_zero=%b", name, f, d_zero, ef, ez);
        end
    endtask

    // Drive d just after a falling edge; output must hold until the next rising edge, then update.
    task automatic apply(input logic [31:0] dv, input logic [31:0] prev_f, input logic prev_z,
                         input logic [31:0] ef, input logic ez, input string name);
        d = dv;
        #1;
        chk({name, "_hold"}, prev_f, prev_z);
        @(negedge clk);
        chk(name, ef, ez);
    endtask

    initial begin
        rst = 1'b1;
        d   = 32'h0000_0005;
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("in_reset", 32'd0, 1'b0);
        end
        chk_en = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("first_edge", 32'h2000_0000, 1'b0);

        apply(32'h0000_0001, 32'h2000_0000, 1'b0, 32'h8000_0000, 1'b0, "d1");
        apply(32'h0000_0002, 32'h8000_0000, 1'b0, 32'h4000_0000, 1'b0, "d2");
        apply(32'h0000_0003, 32'h4000_0000, 1'b0, 32'h4000_0000, 1'b0, "d3");
        apply(32'h8000_0000, 32'h4000_0000, 1'b0, 32'h0000_0001, 1'b0, "msb");
        apply(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0, "all_ones");
        apply(32'h0000_0000, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, "zero");
        apply(32'h0001_0000, 32'h0000_0000, 1'b1, 32'h0000_8000, 1'b0, "d64k");
        apply(32'd7,         32'h0000_8000, 1'b0, 32'h2000_0000, 1'b0, "d7");
        apply(32'd8,         32'h2000_0000, 1'b0, 32'h1000_0000, 1'b0, "d8");
        apply(32'd100,       32'h1000_0000, 1'b0, 32'h0200_0000, 1'b0, "d100");

        // Asynchronous reset between edges.
        apply(32'd2,         32'h0200_0000, 1'b0, 32'h4000_0000, 1'b0, "pre_rst");
        #2 rst = 1'b0;
        #1 chk("async_clear", 32'd0, 1'b0);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("post_rst", 32'h4000_0000, 1'b0);

        // Random nonzero divisors spread across all MSB positions.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] r;
            r = $urandom >> $urandom_range(0, 31);
            if (r == 32'd0) r = 32'd1;
            d = r;
            @(negedge clk);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
